// File: rtl/core_pkg.sv
// Shared types for the RV32I multi-cycle core: sequencer states, trap causes
// and the ALU op encoding agreed between decoder, ALU and sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_ILLEGAL  = 2'd1,
    CAUSE_MISALIGN = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } trap_cause_e;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [7:0] ALU_NONE = 8'h0;
  localparam logic [7:0] ALU_ADD  = 8'h1;
  localparam logic [7:0] ALU_SUB  = 8'h2;
  localparam logic [7:0] ALU_AND  = 8'h3;
  localparam logic [7:0] ALU_OR   = 8'h4;
  localparam logic [7:0] ALU_XOR  = 8'h5;
  localparam logic [7:0] ALU_SLL  = 8'h6;
  localparam logic [7:0] ALU_SRL  = 8'h7;
  localparam logic [7:0] ALU_SRA  = 8'h8;
  localparam logic [7:0] ALU_SLT  = 8'h9;
  localparam logic [7:0] ALU_SLTU = 8'ha;

  // A decode with no ALU op and no register write has no architectural effect.
  function automatic logic is_illegal(input logic [7:0] op, input logic we);
    return (op == ALU_NONE) && !we;
  endfunction

  function automatic logic [31:0] jump_target(input logic [31:0] alu);
    return {alu[31:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Down-counter that bounds how long the sequencer waits for imem_ack.
// Loaded on entry to FETCH, ticks on every non-ack cycle, expire_o on the last one.
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = CW'(TIMEOUT);
    end else if (tick_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A count of 1 means this is the last permitted waiting cycle; TIMEOUT=0 never loads a live count.
  assign expire_o = (TIMEOUT != 0) && (cnt_q == CW'(1));

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH->DECODE->EXEC->WB control for the RV32I core; owns PC, IR and instret.
// imem handshake: imem_req is held with imem_addr stable until the cycle imem_ack is seen.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic [31:0] pc,
  input  logic [7:0]  dec_op,
  input  logic        dec_we,
  input  logic        dec_jmpe,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [31:0] rf_wdata,
  output logic        busy,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [1:0]  cause_q, cause_d;

  logic        wd_load, wd_tick, wd_clear, wd_expire;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  fetch_watchdog #(
    .TIMEOUT (FETCH_TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (wd_load),
    .tick_i   (wd_tick),
    .clear_i  (wd_clear),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_d     = alu_q;
    instret_d = instret_q;
    trap_d    = trap_q;
    cause_d   = cause_q;
    wd_load   = 1'b0;
    wd_tick   = 1'b0;
    wd_clear  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (run) begin
          state_d = FETCH;
          wd_load = 1'b1;
        end
      end

      FETCH: begin
        if (imem_ack) begin
          ir_d     = imem_rdata;
          state_d  = DECODE;
          wd_clear = 1'b1;
        end else if (wd_expire) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          if (!trap_q) cause_d = CAUSE_TIMEOUT;
        end else begin
          wd_tick = 1'b1;
        end
      end

      DECODE: begin
        if (is_illegal(dec_op, dec_we)) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          if (!trap_q) cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        alu_d = alu_result;
        // Bit 0 is dropped at WB, so only bit 1 makes a jump target misaligned.
        if (dec_jmpe && alu_result[1]) begin
          state_d = TRAP;
          trap_d  = 1'b1;
          if (!trap_q) cause_d = CAUSE_MISALIGN;
        end else begin
          state_d = WB;
        end
      end

      WB: begin
        pc_d      = dec_jmpe ? jump_target(alu_q) : pc_plus4;
        instret_d = instret_q + 32'd1;
        if (run) begin
          state_d = FETCH;
          wd_load = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      TRAP: begin
        state_d = TRAP;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSTR;
      alu_q     <= 32'd0;
      instret_q <= 32'd0;
      trap_q    <= 1'b0;
      cause_q   <= CAUSE_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_q     <= alu_d;
      instret_q <= instret_d;
      trap_q    <= trap_d;
      cause_q   <= cause_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign ir         = ir_q;
  assign pc         = pc_q;
  assign rf_we      = (state_q == WB) && dec_we;
  // Jumps link pc+4; everything else writes the value captured in EXEC.
  assign rf_wdata   = (state_q == WB) ? (dec_jmpe ? pc_plus4 : alu_q) : 32'd0;
  assign busy       = (state_q != IDLE) && (state_q != TRAP);
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign instret    = instret_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer with an imem model (programmable ack delay)
// and a small RV32I decoder/ALU/regfile covering addi, jal and jalr.
module tb_core_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ir, pc, alu_result, rf_wdata, instret;
  logic [7:0]  dec_op;
  logic        dec_we, dec_jmpe, rf_we, busy, trap;
  logic [1:0]  trap_cause;
  state_e      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  int   ack_delay    = 0;
  logic ack_withhold = 1'b0;
  logic ack_force    = 1'b0;
  int   wait_cnt     = 0;

  logic [31:0] imem [16];
  logic [31:0] rf [32] = '{default: 32'h0};

  core_sequencer #(
    .RESET_PC      (32'h0000_0000),
    .FETCH_TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ir         (ir),
    .pc         (pc),
    .dec_op     (dec_op),
    .dec_we     (dec_we),
    .dec_jmpe   (dec_jmpe),
    .alu_result (alu_result),
    .rf_we      (rf_we),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .trap       (trap),
    .trap_cause (trap_cause),
    .instret    (instret),
    .dbg_state  (dbg_state)
  );

  // clock / imem model / decoder+ALU+regfile
  always #5 clk = ~clk;

  assign imem_rdata = imem[imem_addr[5:2]];
  assign imem_ack   = (imem_req && !ack_withhold && (wait_cnt >= ack_delay)) || ack_force;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  always_comb begin
    logic [31:0] rs1_val, imm_i, imm_j;
    dec_op     = ALU_NONE;
    dec_we     = 1'b0;
    dec_jmpe   = 1'b0;
    alu_result = 32'd0;
    rs1_val    = (ir[19:15] == 5'd0) ? 32'd0 : rf[ir[19:15]];
    imm_i      = {{20{ir[31]}}, ir[31:20]};
    imm_j      = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
    case (ir[6:0])
      7'h13: if (ir[14:12] == 3'd0) begin
        dec_op = ALU_ADD; dec_we = 1'b1; alu_result = rs1_val + imm_i;
      end
      7'h6f: begin
        dec_op = ALU_ADD; dec_we = 1'b1; dec_jmpe = 1'b1; alu_result = pc + imm_j;
      end
      7'h67: begin
        dec_op = ALU_ADD; dec_we = 1'b1; dec_jmpe = 1'b1; alu_result = rs1_val + imm_i;
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (rf_we && (ir[11:7] != 5'd0)) rf[ir[11:7]] <= rf_wdata;
  end

  // driver / checking tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input state_e s, input int limit, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    n++;
    while ((dbg_state !== s) && (n < limit)) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) imem[i] = NOP_INSTR;
    imem[0] = 32'h0050_0093;  // addi x1,x0,5
    imem[1] = 32'h0200_0113;  // addi x2,x0,0x20
    imem[2] = 32'h0220_0193;  // addi x3,x0,0x22
    imem[3] = 32'h0000_0013;  // nop
    imem[4] = 32'h0080_00ef;  // 0x10: jal x1,+8
    imem[6] = 32'h0011_0067;  // 0x18: jalr x0,1(x2)
    imem[8] = 32'h0001_8067;  // 0x20: jalr x0,0(x3)

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0000_0013);
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_rf_we", 32'(rf_we), 32'h0);
    check("rst_rf_wdata", rf_wdata, 32'h0);
    check("rst_trap", 32'(trap), 32'h0);
    check("rst_cause", 32'(trap_cause), 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;

    // addi x1,x0,5 with 1-cycle fetch, then stop at the boundary
    run = 1'b1;
    wait_state(WB, 20, "addi_reach_wb");
    check("addi_rf_we", 32'(rf_we), 32'h1);
    check("addi_rf_wdata", rf_wdata, 32'h5);
    run = 1'b0;
    @(negedge clk);
    check("addi_pc", pc, 32'h4);
    check("addi_instret", instret, 32'h1);
    check("addi_idle", 32'(dbg_state), 32'(IDLE));
    check("addi_rf_we_pulse", 32'(rf_we), 32'h0);
    check("addi_req_idle", 32'(imem_req), 32'h0);
    check("addi_x1", rf[1], 32'h5);

    // addi x2, addi x3, nop, jal, jalr (aligned), jalr (misaligned)
    run = 1'b1;
    wait_state(WB, 20, "seq_wb_0x4");
    wait_state(WB, 20, "seq_wb_0x8");
    wait_state(WB, 20, "seq_wb_0xc");
    wait_state(WB, 20, "jal_reach_wb");
    check("jal_rf_we", 32'(rf_we), 32'h1);
    check("jal_rf_wdata", rf_wdata, 32'h14);
    @(negedge clk);
    check("jal_pc", pc, 32'h18);
    check("jal_x1", rf[1], 32'h14);
    wait_state(WB, 20, "jalr_reach_wb");
    check("jalr_x0_rf_we", 32'(rf_we), 32'h1);
    check("jalr_rf_wdata", rf_wdata, 32'h1c);
    @(negedge clk);
    check("jalr_pc", pc, 32'h20);
    check("jalr_no_trap", 32'(trap), 32'h0);
    wait_state(TRAP, 20, "misalign_reach_trap");
    check("misalign_trap", 32'(trap), 32'h1);
    check("misalign_cause", 32'(trap_cause), 32'h2);
    check("misalign_pc", pc, 32'h20);
    check("misalign_ir", ir, 32'h0001_8067);
    check("misalign_instret", instret, 32'h6);
    check("misalign_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("trap_rf_we", 32'(rf_we), 32'h0);
      check("trap_req", 32'(imem_req), 32'h0);
    end
    check("trap_sticky", 32'(dbg_state), 32'(TRAP));

    // illegal instruction word 0
    do_reset();
    check("post_rst_trap", 32'(trap), 32'h0);
    check("post_rst_pc", pc, 32'h0);
    imem[0] = 32'h0000_0000;
    run = 1'b1;
    wait_state(TRAP, 20, "illegal_reach_trap");
    check("illegal_cause", 32'(trap_cause), 32'h1);
    check("illegal_pc", pc, 32'h0);
    check("illegal_ir", ir, 32'h0);
    check("illegal_instret", instret, 32'h0);

    // fetch timeout: 16 waiting cycles are tolerated, the 17th is TRAP
    do_reset();
    imem[0] = 32'h0050_0093;
    ack_withhold = 1'b1;
    run = 1'b1;
    @(negedge clk);
    repeat (15) @(negedge clk);
    check("timeout_still_fetch", 32'(dbg_state), 32'(FETCH));
    check("timeout_req_held", 32'(imem_req), 32'h1);
    @(negedge clk);
    check("timeout_state", 32'(dbg_state), 32'(TRAP));
    check("timeout_cause", 32'(trap_cause), 32'h3);
    check("timeout_req_drop", 32'(imem_req), 32'h0);
    ack_withhold = 1'b0;

    // run dropped during EXEC, 2-cycle ack delay
    do_reset();
    ack_delay = 2;
    run = 1'b1;
    wait_state(EXEC, 30, "stop_reach_exec");
    run = 1'b0;
    @(negedge clk);
    check("stop_wb_state", 32'(dbg_state), 32'(WB));
    check("stop_rf_we", 32'(rf_we), 32'h1);
    check("stop_rf_wdata", rf_wdata, 32'h5);
    @(negedge clk);
    check("stop_idle", 32'(dbg_state), 32'(IDLE));
    check("stop_req", 32'(imem_req), 32'h0);
    check("stop_pc", pc, 32'h4);
    check("stop_instret", instret, 32'h1);
    repeat (3) @(negedge clk);
    check("stop_stays_idle", 32'(dbg_state), 32'(IDLE));

    // reset while a fetch is pending; a stray ack afterwards is ignored
    ack_delay = 3;
    run = 1'b1;
    wait_state(FETCH, 10, "rstfetch_reach_fetch");
    rst_n = 1'b0;
    @(negedge clk);
    check("rstfetch_pc", pc, 32'h0);
    check("rstfetch_trap", 32'(trap), 32'h0);
    check("rstfetch_req", 32'(imem_req), 32'h0);
    check("rstfetch_state", 32'(dbg_state), 32'(IDLE));
    check("rstfetch_instret", instret, 32'h0);
    rst_n = 1'b1;
    run = 1'b0;
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("late_ack_ir", ir, 32'h0000_0013);
    check("late_ack_state", 32'(dbg_state), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
